sccb_responder: RTL and testbench

- SCCB target (camera-side) model. It answers 3-phase write and 2-phase write / 2-phase read transactions from the on-chip SCCB initiator.
- Holds a 256 x 8 register file. Product-ID and soft-reset semantics mimic the OV7670.
- Used as the loop-back partner for initiator verification and for FPGA bring-up without a camera attached.
- All logic runs on PCLK; it oversamples SIOC/SIOD and never uses SIOC as a clock.

---
 rtl/sccb_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_sccb_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB target (camera-side) model with an OV7670-like
// 256 x 8 register file. It answers 3-phase writes and 2-phase write /
// 2-phase read transactions. Everything runs on PCLK. SIOC and SIOD are
// oversampled and SIOC is never used as a clock.
//
// Ports:
//   PCLK       system clock
//   PRESET     asynchronous active-high reset
//   sioc       SCCB clock from the initiator (asynchronous to PCLK)
//   siod_i     SCCB data, pad input
//   siod_o     SCCB data driven by this block
//   siod_o_en  pad output enable (1 = drive siod_o)
//   reg_wr     one-PCLK pulse when a register write commits
//   reg_addr   sub-address of the last committed write
//   reg_data   data of the last committed write
//   busy       high from START until STOP, or until the transaction is dropped
module sccb_responder #(
  parameter logic [6:0] DEV_ID  = 7'h21,
  parameter logic [7:0] PID_MSB = 8'h76,
  parameter logic [7:0] PID_LSB = 8'h73
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       sioc,
  input  logic       siod_i,
  output logic       siod_o,
  output logic       siod_o_en,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE,
    ID,
    ID_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_NA,
    WAIT_STOP,
    IGNORE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        rw, rw_n;
  logic [7:0]  sub_addr, sub_addr_n;
  logic        siod_o_n, siod_o_en_n, busy_n;
  logic        reg_wr_n;
  logic [7:0]  reg_addr_n, reg_data_n;
  logic        commit;

  logic [7:0]  regs [256];

  // [0],[1] synchronize, [2] holds the previous synced value for edge detect.
  // Reset to the idle-bus level so reset release does not look like an edge.
  logic [2:0]  sioc_q, siod_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sioc_q <= '1;
      siod_q <= '1;
    end else begin
      sioc_q <= {sioc_q[1:0], sioc};
      siod_q <= {siod_q[1:0], siod_i};
    end
  end

  logic sc_rise, sc_fall, sda, start_c, stop_c;
  assign sc_rise = sioc_q[1] & ~sioc_q[2];
  assign sc_fall = ~sioc_q[1] & sioc_q[2];
  assign sda     = siod_q[1];
  assign start_c = sioc_q[1] & sioc_q[2] & ~siod_q[1] &  siod_q[2];
  assign stop_c  = sioc_q[1] & sioc_q[2] &  siod_q[1] & ~siod_q[2];

  logic [7:0] rd_val;
  assign rd_val = (sub_addr == 8'h0A) ? PID_MSB :
                  (sub_addr == 8'h0B) ? PID_LSB : regs[sub_addr];

  logic soft_rst;
  assign soft_rst = (sub_addr == 8'h12) && shift[7];

  logic shift_in;
  assign shift_in = sc_rise && (bit_cnt != 4'd8);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    rw_n        = rw;
    sub_addr_n  = sub_addr;
    siod_o_n    = siod_o;
    siod_o_en_n = siod_o_en;
    busy_n      = busy;
    reg_wr_n    = 1'b0;
    reg_addr_n  = reg_addr;
    reg_data_n  = reg_data;
    commit      = 1'b0;

    // START has priority over any bit edge seen in the same cycle.
    if (start_c) begin
      state_n     = ID;
      bit_cnt_n   = '0;
      busy_n      = 1'b1;
      siod_o_en_n = 1'b0;
      siod_o_n    = 1'b0;
    end else if (stop_c) begin
      state_n     = IDLE;
      busy_n      = 1'b0;
      siod_o_en_n = 1'b0;
      siod_o_n    = 1'b0;
    end else begin
      case (state)
        ID: begin
          if (shift_in) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (sc_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (shift[7:1] == DEV_ID) begin
              rw_n        = shift[0];
              siod_o_n    = 1'b0;
              siod_o_en_n = 1'b1;
              state_n     = ID_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end
        end
        ID_ACK: begin
          if (sc_fall) begin
            bit_cnt_n = '0;
            if (rw) begin
              // Ack release and the first read bit share this edge.
              shift_n     = rd_val;
              siod_o_n    = rd_val[7];
              siod_o_en_n = 1'b1;
              state_n     = RDATA;
            end else begin
              siod_o_en_n = 1'b0;
              state_n     = SUB;
            end
          end
        end
        SUB: begin
          if (shift_in) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (sc_fall && bit_cnt == 4'd8) begin
            bit_cnt_n   = '0;
            sub_addr_n  = shift;
            siod_o_n    = 1'b0;
            siod_o_en_n = 1'b1;
            state_n     = SUB_ACK;
          end
        end
        SUB_ACK: begin
          if (sc_fall) begin
            bit_cnt_n   = '0;
            siod_o_en_n = 1'b0;
            state_n     = WDATA;
          end
        end
        WDATA: begin
          if (shift_in) begin
            shift_n   = {shift[6:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (sc_fall && bit_cnt == 4'd8) begin
            bit_cnt_n   = '0;
            siod_o_n    = 1'b0;
            siod_o_en_n = 1'b1;
            state_n     = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          if (sc_fall) begin
            siod_o_en_n = 1'b0;
            state_n     = WAIT_STOP;
            if (sub_addr != 8'h0A && sub_addr != 8'h0B) begin
              commit     = 1'b1;
              reg_wr_n   = 1'b1;
              reg_addr_n = sub_addr;
              reg_data_n = shift;
            end
          end
        end
        RDATA: begin
          if (shift_in) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (sc_fall) begin
            if (bit_cnt == 4'd8) begin
              siod_o_n    = 1'b0;
              siod_o_en_n = 1'b0;
              state_n     = RD_NA;
            end else begin
              shift_n  = {shift[6:0], 1'b0};
              siod_o_n = shift[6];
            end
          end
        end
        RD_NA: begin
          if (sc_rise) state_n = WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rw        <= 1'b0;
      sub_addr  <= '0;
      siod_o    <= 1'b0;
      siod_o_en <= 1'b0;
      busy      <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      rw        <= rw_n;
      sub_addr  <= sub_addr_n;
      siod_o    <= siod_o_n;
      siod_o_en <= siod_o_en_n;
      busy      <= busy_n;
      reg_wr    <= reg_wr_n;
      reg_addr  <= reg_addr_n;
      reg_data  <= reg_data_n;
    end
  end

  // A soft reset clears the whole file, including 0x12 itself.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < 256; i++) regs[i] <= '0;
    end else if (commit) begin
      if (soft_rst) begin
        for (int unsigned i = 0; i < 256; i++) regs[i] <= '0;
      end else begin
        regs[sub_addr] <= shift;
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bit-level SCCB initiator driving sccb_responder over an
// open-drain SIOD line, checked against a register-file model.
module tb_sccb_responder;

  localparam int Q = 6;  // PCLK cycles per quarter SCCB bit

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       sioc = 1'b1;
  logic       m_sda = 1'b1;
  logic       siod_line;
  logic       siod_o, siod_o_en, reg_wr, busy;
  logic [7:0] reg_addr, reg_data;

  assign siod_line = (siod_o_en && !siod_o) ? 1'b0 : m_sda;

  sccb_responder #(.DEV_ID(7'h21), .PID_MSB(8'h76), .PID_LSB(8'h73)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .sioc(sioc), .siod_i(siod_line),
    .siod_o(siod_o), .siod_o_en(siod_o_en), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_data(reg_data), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int         wr_cnt = 0;
  int         en_cyc = 0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  always @(negedge PCLK) begin
    if (reg_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= reg_addr;
      wr_data <= reg_data;
    end
    if (siod_o_en) en_cyc <= en_cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the register file as seen by the initiator.
  logic [7:0] mregs [256];
  logic [7:0] msub;

  task automatic m_reset();
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    msub = 8'h00;
  endtask

  task automatic m_write(input logic [7:0] a, input logic [7:0] d, output logic pulse);
    msub  = a;
    pulse = 1'b1;
    if (a == 8'h0A || a == 8'h0B) pulse = 1'b0;
    else if (a == 8'h12 && d[7]) for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    else mregs[a] = d;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a == 8'h0A) return 8'h76;
    if (a == 8'h0B) return 8'h73;
    return mregs[a];
  endfunction

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge PCLK);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq();
    sioc  = 1'b1; wq();
    m_sda = 1'b0; wq();
    sioc  = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq();
    sioc  = 1'b1; wq();
    m_sda = 1'b1; wq(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wq();
      sioc = 1'b1; wq(2);
      sioc = 1'b0; wq();
    end
    m_sda = 1'b1; wq();
    sioc = 1'b1; wq();
    ack = siod_line;
    check(tag, {31'd0, ack}, exp_ack ? 32'd0 : 32'd1);
    wq();
    sioc = 1'b0; wq();
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic [7:0] v;
    v = '0;
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq();
      sioc = 1'b1; wq();
      v[i] = siod_line; wq();
      sioc = 1'b0; wq();
    end
    wq();
    sioc = 1'b1; wq();
    check("na_released", {31'd0, siod_o_en}, 32'd0);
    wq();
    sioc = 1'b0; wq();
    b = v;
  endtask

  task automatic txn_write3(input logic [7:0] a, input logic [7:0] d);
    int   w0;
    logic pulse;
    w0 = wr_cnt;
    bus_start();
    check("busy_at_start", {31'd0, busy}, 32'd1);
    send_byte(8'h42, 1'b1, "id_ack");
    send_byte(a, 1'b1, "sub_ack");
    send_byte(d, 1'b1, "data_ack");
    check("busy_before_stop", {31'd0, busy}, 32'd1);
    bus_stop();
    m_write(a, d, pulse);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    check("wr_pulses", wr_cnt - w0, {31'd0, pulse});
    if (pulse) begin
      check("wr_addr", {24'd0, wr_addr}, {24'd0, a});
      check("wr_data", {24'd0, wr_data}, {24'd0, d});
    end
  endtask

  task automatic txn_write2(input logic [7:0] a);
    int w0;
    w0 = wr_cnt;
    bus_start();
    send_byte(8'h42, 1'b1, "id2_ack");
    send_byte(a, 1'b1, "sub2_ack");
    bus_stop();
    msub = a;
    check("wr2_no_pulse", wr_cnt - w0, 32'd0);
  endtask

  task automatic txn_read(input string tag);
    logic [7:0] d;
    bus_start();
    send_byte(8'h43, 1'b1, "idr_ack");
    recv_byte(d);
    bus_stop();
    check("en_after_stop", {31'd0, siod_o_en}, 32'd0);
    check(tag, {24'd0, d}, {24'd0, m_read(msub)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int         w0, e0;
    logic [7:0] a, d;
    m_reset();

    // Reset state
    repeat (5) @(negedge PCLK);
    check("rst_siod_o", {31'd0, siod_o}, 32'd0);
    check("rst_siod_o_en", {31'd0, siod_o_en}, 32'd0);
    check("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    check("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_reg_data", {24'd0, reg_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    PRESET = 1'b0;
    wq(2);

    // 3-phase write and read-back
    txn_write3(8'h15, 8'h3C);
    txn_write2(8'h15);
    txn_read("readback_15");

    // Product ID, and writes to it are dropped
    txn_write2(8'h0A);
    txn_read("pid_msb");
    txn_write2(8'h0B);
    txn_read("pid_lsb");
    txn_write3(8'h0A, 8'h55);
    txn_write2(8'h0A);
    txn_read("pid_msb_after_write");

    // Soft reset
    txn_write3(8'h15, 8'hAA);
    txn_write3(8'h12, 8'h80);
    txn_write2(8'h15);
    txn_read("soft_rst_15");
    txn_write2(8'h12);
    txn_read("soft_rst_12");

    // Wrong ID: never drives, drops busy, no commit
    w0 = wr_cnt;
    e0 = en_cyc;
    bus_start();
    send_byte(8'h44, 1'b0, "wrong_id_noack");
    check("wrong_id_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h12, 1'b0, "wrong_id_sub_noack");
    send_byte(8'h34, 1'b0, "wrong_id_data_noack");
    bus_stop();
    check("wrong_id_en_cycles", en_cyc - e0, 32'd0);
    check("wrong_id_wr", wr_cnt - w0, 32'd0);

    // Randomized writes and read-backs
    for (int it = 0; it < 10; it++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom);
      if (it % 4 == 3) a = 8'h12;
      txn_write3(a, d);
      a = 8'($urandom_range(0, 255));
      txn_write2(a);
      txn_read("rand_read");
    end

    // Abort with PRESET during read data bit 3
    txn_write3(8'h20, 8'h5A);
    txn_write2(8'h20);
    bus_start();
    send_byte(8'h43, 1'b1, "abort_id_ack");
    m_sda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wq();
      sioc = 1'b1; wq(2);
      sioc = 1'b0; wq();
    end
    check("abort_driving", {31'd0, siod_o_en}, 32'd1);
    PRESET = 1'b1;
    #1;
    check("abort_en", {31'd0, siod_o_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    sioc  = 1'b1;
    m_sda = 1'b1;
    wq();
    PRESET = 1'b0;
    m_reset();
    wq(2);
    txn_write3(8'h33, 8'h99);
    txn_write2(8'h33);
    txn_read("after_abort_33");
    txn_write2(8'h20);
    txn_read("after_abort_20");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
